// File: rtl/fifo_sr_dispatch.sv
// Drain stage of the shared-resource multi-flux FIFO.
// Scans per-flux empty flags round-robin, issues a one-hot read strobe, captures the
// muxed FIFO word and presents one registered valid/ready stream per flux.
// Optional: define DISPATCH_TAGCHK_EN to add a sticky tag-mismatch flag (tag_err).
module fifo_sr_dispatch #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLUX       = 2,
  localparam int unsigned TAG_WIDTH = $clog2(FLUX)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [FLUX-1:0]                fifo_empty,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_dout,
  output logic [FLUX-1:0]                fifo_read,
  output logic [FLUX*DATA_WIDTH-1:0]     m_data,
  output logic [FLUX-1:0]                m_valid,
  input  logic [FLUX-1:0]                m_ready
`ifdef DISPATCH_TAGCHK_EN
  ,
  output logic                           tag_err
`endif
);

  logic [FLUX-1:0]            m_valid_q, m_valid_d;
  logic [FLUX*DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [TAG_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
  logic [FLUX-1:0]            elig;
  logic                       grant_vld;
  logic [TAG_WIDTH-1:0]       grant_idx;
  logic [TAG_WIDTH-1:0]       scan_idx;

  // Eligibility: a flux draining this cycle may be refilled in the same cycle.
  // rst gates it so the read strobe is dead during reset.
  always_comb begin
    elig = {FLUX{en & ~rst}} & ~fifo_empty & (~m_valid_q | m_ready);
  end

  // Round-robin scan starting at rr_ptr, wrapping FLUX-1 -> 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = rr_ptr_q;
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (!grant_vld && elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = (scan_idx == TAG_WIDTH'(FLUX - 1)) ? '0 : scan_idx + TAG_WIDTH'(1);
    end
  end

  // Read strobe is combinational and at most one-hot.
  always_comb begin
    fifo_read = grant_vld ? (FLUX'(1) << grant_idx) : '0;
  end

  // Next state for output registers and the round-robin pointer.
  always_comb begin
    m_valid_d = m_valid_q & ~m_ready;
    m_data_d  = m_data_q;
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (fifo_read[f]) begin
        m_valid_d[f]                    = 1'b1;
        m_data_d[f*DATA_WIDTH +: DATA_WIDTH] = fifo_dout[DATA_WIDTH-1:0];
      end
    end
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == TAG_WIDTH'(FLUX - 1)) ? '0 : grant_idx + TAG_WIDTH'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= '0;
      m_data_q  <= '0;
      rr_ptr_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef DISPATCH_TAGCHK_EN
  logic tag_err_q, tag_err_d;

  // Sticky: any grant whose word carries a tag other than the granted flux.
  always_comb begin
    tag_err_d = tag_err_q |
                (grant_vld & (fifo_dout[DATA_WIDTH +: TAG_WIDTH] != grant_idx));
  end

  // Tag error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_err_q <= 1'b0;
    end else begin
      tag_err_q <= tag_err_d;
    end
  end

  assign tag_err = tag_err_q;
`else
  // Tag bits are intentionally ignored in this build.
  logic unused_tag;
  assign unused_tag = ^fifo_dout[DATA_WIDTH +: TAG_WIDTH];
`endif

endmodule

// File: tb/tb_fifo_sr_dispatch.sv
// Randomized bench for fifo_sr_dispatch (DATA_WIDTH=8, FLUX=2) against a queue-based model.
// Define DISPATCH_TAGCHK_EN to also exercise the tag check.
module tb_fifo_sr_dispatch;
  localparam int DW = 8;
  localparam int FL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [FL-1:0] fifo_empty;
  logic [DW:0]   fifo_dout;
  logic [FL-1:0] fifo_read;
  logic [FL*DW-1:0] m_data;
  logic [FL-1:0] m_valid;
  logic [FL-1:0] m_ready;
`ifdef DISPATCH_TAGCHK_EN
  logic          tag_err;
`endif

  fifo_sr_dispatch #(.DATA_WIDTH(DW), .FLUX(FL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef DISPATCH_TAGCHK_EN
    ,
    .tag_err    (tag_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: FIFO contents per flux, one output slot per flux, next-flux-to-scan pointer.
  logic [DW-1:0] fq [FL][$];
  bit            mv [FL];
  logic [DW-1:0] md [FL];
  int            rr = 0;
  bit            bad_tag = 0;
  bit            exp_tag_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int f, input logic [DW-1:0] d);
    fq[f].push_back(d);
  endtask

  task automatic model_reset();
    for (int f = 0; f < FL; f++) mv[f] = 0;
    rr = 0;
    exp_tag_err = 0;
  endtask

  // One clock: drive at negedge, check 1ns later, advance model, wait for posedge.
  task automatic step(input logic en_v, input logic [FL-1:0] rdy);
    int g;
    logic [FL-1:0] exp_rd;
    logic tagv;
    @(negedge clk);
    en = en_v;
    m_ready = rdy;
    for (int f = 0; f < FL; f++) fifo_empty[f] = (fq[f].size() == 0);
    g = -1;
    for (int i = 0; i < FL; i++) begin
      int f;
      f = (rr + i) % FL;
      if (g < 0 && en_v && fq[f].size() > 0 && (!mv[f] || rdy[f])) g = f;
    end
    exp_rd = '0;
    if (g >= 0) begin
      exp_rd[g] = 1'b1;
      tagv = (g == 1);
      if (bad_tag) tagv = ~tagv;
      fifo_dout = {tagv, fq[g][0]};
    end else begin
      fifo_dout = 9'($urandom);
    end
    #1;
    check_eq("fifo_read", 32'(fifo_read), 32'(exp_rd));
    check_eq("m_valid", 32'(m_valid), 32'({mv[1], mv[0]}));
    for (int f = 0; f < FL; f++)
      if (mv[f]) check_eq("m_data", 32'(m_data[f*DW +: DW]), 32'(md[f]));
`ifdef DISPATCH_TAGCHK_EN
    check_eq("tag_err", 32'(tag_err), 32'(exp_tag_err));
`endif
    for (int f = 0; f < FL; f++) if (mv[f] && rdy[f]) mv[f] = 0;
    if (g >= 0) begin
      mv[g] = 1;
      md[g] = fq[g].pop_front();
      rr = (g + 1) % FL;
      if (bad_tag) exp_tag_err = 1;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) step(1'b1, 2'b11);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = '0; fifo_empty = '1; fifo_dout = '0;
    model_reset();
    #12;
    check_eq("rst_valid", 32'(m_valid), 0);
    check_eq("rst_data", 32'(m_data), 0);
    check_eq("rst_read", 32'(fifo_read), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single flux: word 0A5 into flux 0 only.
    push(0, 8'hA5);
    step(1'b1, 2'b01);
    #1;
    check_eq("single_valid", 32'(m_valid), 32'h1);
    check_eq("single_data", 32'(m_data[7:0]), 32'hA5);
    drain();

    // Round-robin with both fluxes busy and consumers ready.
    for (int i = 0; i < 4; i++) begin
      push(0, 8'($urandom));
      push(1, 8'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1'b1, 2'b11);
    drain();

    // Backpressure on flux 1 then same-cycle refill.
    for (int i = 0; i < 3; i++) push(1, 8'($urandom));
    step(1'b1, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b1, 2'b10);
    drain();

    // en low: no reads, held words drain, then resume.
    for (int i = 0; i < 3; i++) begin
      push(0, 8'($urandom));
      push(1, 8'($urandom));
    end
    step(1'b1, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int f = 0; f < FL; f++)
        if ($urandom_range(0, 2) == 0) push(f, 8'($urandom));
      step(($urandom_range(0, 7) != 0), 2'($urandom));
    end
    drain();

`ifdef DISPATCH_TAGCHK_EN
    // Wrong tag on a flux-1 grant sets the sticky flag; data still captured.
    push(1, 8'hFF);
    bad_tag = 1;
    step(1'b1, 2'b00);
    bad_tag = 0;
    #1;
    check_eq("tag_err_set", 32'(tag_err), 1);
    check_eq("tag_data", 32'(m_data[15:8]), 32'hFF);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b11);
`endif

    // Asynchronous reset mid-stream with both outputs full.
    for (int i = 0; i < 2; i++) begin
      push(0, 8'($urandom));
      push(1, 8'($urandom));
    end
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00);
    check_eq("pre_rst_valid", 32'(m_valid), 32'h3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    en = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(m_valid), 0);
    check_eq("mid_rst_read", 32'(fifo_read), 0);
    check_eq("mid_rst_data", 32'(m_data), 0);
`ifdef DISPATCH_TAGCHK_EN
    check_eq("mid_rst_tag_err", 32'(tag_err), 0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'b11);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_sr_dispatch.md
Name: fifo_sr_dispatch

Overview:
- Downstream drain stage of the shared-resource multi-flux FIFO.
- Watches the per-flux empty flags and issues one-hot per-flux read strobes.
- Captures the muxed FIFO output word, strips the tag, and presents one registered valid/ready stream per flux.
- Round-robin arbitration stops a busy flux from starving the others out of the shared memory.

Parameters:
- DATA_WIDTH, 8, payload bits per word (excluding tag).
- FLUX, 2, number of fluxes; legal range FLUX >= 2.
- TAG_WIDTH, $clog2(FLUX), derived localparam; tag occupies the MSBs of the FIFO word.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  dispatch enable; when low no new reads are issued.
- fifo_empty  input  FLUX  per-flux empty flags from the FIFO.
- fifo_dout  input  DATA_WIDTH+TAG_WIDTH  FIFO output word, valid in the same cycle as the read strobe.
- fifo_read  output  FLUX  one-hot (or zero) read strobe to the FIFO.
- m_data  output  FLUX*DATA_WIDTH  per-flux payload; flux f occupies bits [f*DATA_WIDTH +: DATA_WIDTH].
- m_valid  output  FLUX  per-flux output valid.
- m_ready  input  FLUX  per-flux consumer ready.
- tag_err  output  1  sticky tag-mismatch flag; present only with DISPATCH_TAGCHK_EN.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-transfer:
  - m_valid = 0, m_data = 0, rr_ptr = 0, tag_err = 0.
  - fifo_read is forced to 0 while rst is high.
  - Any held words are discarded.
- Eligibility, per flux f: elig[f] = en & !fifo_empty[f] & (!m_valid[f] | m_ready[f]).
  - A flux whose output register drains this cycle may be refilled in the same cycle.
- Arbitration:
  - Grant = first f with elig[f], scanning rr_ptr, rr_ptr+1, ... modulo FLUX.
  - fifo_read = onehot(grant) when any elig, else 0.
  - fifo_read is combinational and never has more than one bit set.
- rr_ptr:
  - On a grant, rr_ptr <= (grant+1) mod FLUX, wrapping FLUX-1 -> 0.
  - With no grant, rr_ptr holds.
- Capture:
  - On a grant to g, m_data[g] <= fifo_dout[DATA_WIDTH-1:0] and m_valid[g] <= 1 at the next edge.
  - Read-to-valid latency is 1 cycle.
  - Aggregate throughput is one word per cycle; per-flux throughput is one word per cycle when it is the only eligible flux.
- Output handshake, per flux f:
  - A transfer occurs when m_valid[f] & m_ready[f].
  - After a transfer without a refill, m_valid[f] <= 0.
  - Transfer and refill in the same cycle: m_valid[f] stays 1 and new data is loaded.
  - While m_valid[f] & !m_ready[f], m_data[f] is held stable and flux f is not eligible.
- Empty flag timing:
  - fifo_empty is registered inside the FIFO, so reading a flux's last word leaves empty high from the next cycle; no extra guard is needed.
  - fifo_empty high suppresses the read even if the consumer is ready.
- en low:
  - No reads are issued.
  - Existing m_valid words still drain normally.
  - rr_ptr holds.
- Simultaneous eligibility: exactly one flux is served per cycle; the others wait, with bounded wait of FLUX-1 cycles.

Optional Feature:
- Macro: DISPATCH_TAGCHK_EN.
- Defined:
  - On every grant g, compare fifo_dout[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH] with g.
  - On mismatch, tag_err <= 1 and stays set until rst.
  - Data is still captured normally.
- Undefined:
  - tag_err port and comparator are absent.
  - Tag bits are ignored.

Test Plan (DATA_WIDTH=8, FLUX=2 unless stated):
- Reset mid-stream: rst asserted asynchronously between edges while m_valid=2'b11 -> m_valid=0, fifo_read=0, rr_ptr=0 immediately; after release, first grant goes to flux 0 if eligible.
- Single flux: fifo_empty=2'b10, m_ready=2'b01, fifo_dout=9'h0A5 -> fifo_read=2'b01; next cycle m_valid[0]=1 and m_data[7:0]=8'hA5.
- Round-robin: both fluxes non-empty, m_ready=2'b11 for 4 cycles -> fifo_read sequence 01,10,01,10; m_valid stays 2'b11 after fill.
- Backpressure: flux 1 valid with m_ready[1]=0 for 3 cycles, flux 1 non-empty -> no fifo_read[1] for those cycles and m_data[15:8] stable; m_ready[1]=1 -> a same-cycle refill is read.
- en=0 with both fluxes non-empty -> fifo_read=0 throughout; held words drain; en=1 -> arbitration resumes from the held rr_ptr.
- DISPATCH_TAGCHK_EN: grant to flux 1 with fifo_dout=9'h0FF (tag 0) -> tag_err=1 next cycle and stays 1 until rst; m_data[15:8]=8'hFF.
